eth_payload_inserter: RTL and testbench

Single-clock successor to the encoder-to-Ethernet bridge. Buffers a byte stream, e.g. JPEG, in an internal synchronous FIFO. Splices the bytes into the user-data slots of a pre-formed Ethernet lane stream (MII nibbles or GMII bytes) and requests frame transmission once enough payload is buffered. Adds a parametrised lane width, configurable pipeline delay, nibble order, underrun fill with flagging, backpressure and per-frame byte accounting.

---
 rtl/eth_payload_inserter.sv | 141 ++++++++++++++
 tb/tb_eth_payload_inserter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_payload_inserter.sv
// Buffers a payload byte stream in a synchronous FIFO and splices it into the user slots of an MII/GMII lane stream.
// Lane latency is PIPE_DLY+1 cycles; in_ready drops only while the FIFO is full, and an empty FIFO at a slot emits FILL_BYTE.
module eth_payload_inserter #(
    parameter int         LANE_W       = 4,
    parameter int         DEPTH_LOG2   = 12,
    parameter int         START_THRESH = 1024,
    parameter int         PIPE_DLY     = 2,
    parameter int         LSN_FIRST    = 1,
    parameter logic [7:0] FILL_BYTE    = 8'h00
) (
    input  logic                  eth_clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic [LANE_W-1:0]     lane_in,
    input  logic                  lane_user,
    input  logic                  lane_valid,
    output logic [LANE_W-1:0]     lane_out,
    output logic                  lane_out_valid,
    output logic                  start_send,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic [15:0]           frame_bytes
);

    localparam int                DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] THRESH_LVL = (DEPTH_LOG2 + 1)'(START_THRESH);
    localparam bit                IS_MII     = (LANE_W == 4);
    localparam int                DS         = PIPE_DLY - 1;  // splice-feeding stage index
    localparam int                FS         = PIPE_DLY - 2;  // fetch-decision stage index

    logic [7:0]                   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]        wr_ptr;
    logic [DEPTH_LOG2-1:0]        rd_ptr;
    logic [7:0]                   rd_q;
    logic                         byte_fill;

    logic [PIPE_DLY-1:0][LANE_W-1:0] pl_sym;
    logic [PIPE_DLY-1:0]          pl_user;
    logic [PIPE_DLY-1:0]          pl_vld;

    logic                         ph_d;
    logic                         ph_fetch;
    logic                         fetch;
    logic                         wr;
    logic                         rd;
    logic [DEPTH_LOG2:0]          level_nxt;
    logic [7:0]                   cur_byte;
    logic [LANE_W-1:0]            splice_sym;
    logic                         consume;

    // Phase of the slot at the fetch stage follows from the slot one stage ahead of it.
    always_comb begin
        ph_fetch  = IS_MII && pl_user[DS] && !ph_d;
        fetch     = pl_user[FS] && !ph_fetch;
        wr        = in_valid && in_ready;
        rd        = fetch && (level != '0);
        level_nxt = level + (DEPTH_LOG2 + 1)'(wr) - (DEPTH_LOG2 + 1)'(rd);
        cur_byte  = byte_fill ? FILL_BYTE : rd_q;
        consume   = pl_user[DS] && !ph_d;
    end

    generate
        if (LANE_W == 8) begin : g_gmii
            assign splice_sym = cur_byte;
        end else begin : g_mii
            logic sel_lo;
            assign sel_lo     = ph_d ^ (LSN_FIRST != 0);
            assign splice_sym = sel_lo ? cur_byte[3:0] : cur_byte[7:4];
        end
    endgenerate

    always_ff @(posedge eth_clk) begin
        if (wr) begin
            mem[wr_ptr] <= in_data;
        end
        if (rd) begin
            rd_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_ready  <= 1'b0;
            byte_fill <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (fetch) begin
                byte_fill <= (level == '0);
            end
            level    <= level_nxt;
            in_ready <= (level_nxt != FULL_LVL);
        end
    end

    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            pl_sym  <= '0;
            pl_user <= '0;
            pl_vld  <= '0;
            ph_d    <= 1'b0;
        end else begin
            pl_sym  <= {pl_sym[PIPE_DLY-2:0], lane_in};
            pl_user <= {pl_user[PIPE_DLY-2:0], lane_user};
            pl_vld  <= {pl_vld[PIPE_DLY-2:0], lane_valid};
            ph_d    <= ph_fetch;
        end
    end

    // Splice stage: frame_bytes restarts on the first valid slot of a frame.
    always_ff @(posedge eth_clk or posedge rst) begin
        if (rst) begin
            lane_out       <= '0;
            lane_out_valid <= 1'b0;
            start_send     <= 1'b0;
            underrun       <= 1'b0;
            frame_bytes    <= '0;
        end else begin
            lane_out       <= pl_user[DS] ? splice_sym : pl_sym[DS];
            lane_out_valid <= pl_vld[DS];
            start_send     <= !pl_vld[DS] && (level >= THRESH_LVL);
            underrun       <= consume && byte_fill;
            if (pl_vld[DS] && !lane_out_valid) begin
                frame_bytes <= consume ? 16'd1 : 16'd0;
            end else if (consume && (frame_bytes != 16'hFFFF)) begin
                frame_bytes <= frame_bytes + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_payload_inserter.sv
// Drives three inserter variants (MII low-nibble-first, MII high-nibble-first, GMII) from one stimulus stream
// and compares every cycle against a queue-based reference model of the slot/byte rules.
module tb_eth_payload_inserter;

    localparam int         DL     = 4;
    localparam int         DEPTH  = 16;
    localparam int         THRESH = 10;
    localparam logic [7:0] FILL   = 8'h00;

    logic       eth_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic [7:0] lane_in8  = 8'h00;
    logic       lane_user = 1'b0;
    logic       lane_valid = 1'b0;

    logic [2:0]  in_ready, lane_out_valid, start_send, underrun;
    logic [3:0]  lo0, lo1;
    logic [7:0]  lo2;
    logic [DL:0] lvl0, lvl1, lvl2;
    logic [15:0] fb0, fb1, fb2;

    always #5 eth_clk = ~eth_clk;

    eth_payload_inserter #(.LANE_W(4), .DEPTH_LOG2(DL), .START_THRESH(THRESH), .PIPE_DLY(2),
                           .LSN_FIRST(1), .FILL_BYTE(FILL)) u_mii_lsn (
        .eth_clk(eth_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
        .lane_in(lane_in8[3:0]), .lane_user(lane_user), .lane_valid(lane_valid), .lane_out(lo0),
        .lane_out_valid(lane_out_valid[0]), .start_send(start_send[0]), .level(lvl0),
        .underrun(underrun[0]), .frame_bytes(fb0));

    eth_payload_inserter #(.LANE_W(4), .DEPTH_LOG2(DL), .START_THRESH(THRESH), .PIPE_DLY(2),
                           .LSN_FIRST(0), .FILL_BYTE(FILL)) u_mii_msn (
        .eth_clk(eth_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
        .lane_in(lane_in8[3:0]), .lane_user(lane_user), .lane_valid(lane_valid), .lane_out(lo1),
        .lane_out_valid(lane_out_valid[1]), .start_send(start_send[1]), .level(lvl1),
        .underrun(underrun[1]), .frame_bytes(fb1));

    eth_payload_inserter #(.LANE_W(8), .DEPTH_LOG2(DL), .START_THRESH(THRESH), .PIPE_DLY(2),
                           .LSN_FIRST(1), .FILL_BYTE(FILL)) u_gmii (
        .eth_clk(eth_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[2]),
        .lane_in(lane_in8), .lane_user(lane_user), .lane_valid(lane_valid), .lane_out(lo2),
        .lane_out_valid(lane_out_valid[2]), .start_send(start_send[2]), .level(lvl2),
        .underrun(underrun[2]), .frame_bytes(fb2));

    int errs   = 0;
    int checks = 0;

    // Reference model state, one FIFO queue and nibble phase per variant.
    logic [7:0] mq [3][$];
    bit         m_rdy [3];
    bit         m_ph  [3];
    logic [7:0] m_cur [3];
    int         m_fb  [3];
    bit         m_ovld;
    logic [7:0] pv_sym;
    bit         pv_user, pv_vld;
    logic [7:0] e_sym [3];
    bit         e_vld;
    bit         e_und [3];
    int         e_fb  [3];
    bit         e_ss  [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_rdy[d] = 1'b0;
            m_ph[d]  = 1'b0;
            m_cur[d] = 8'h00;
            m_fb[d]  = 0;
            e_sym[d] = 8'h00;
            e_und[d] = 1'b0;
            e_fb[d]  = 0;
            e_ss[d]  = 1'b0;
        end
        m_ovld  = 1'b0;
        e_vld   = 1'b0;
        pv_sym  = 8'h00;
        pv_user = 1'b0;
        pv_vld  = 1'b0;
    endtask

    // One clock edge: the slot sampled last edge fetches its byte, then this edge's write lands.
    task automatic model_step();
        bit wr_ok, cons, fill, lo;
        for (int d = 0; d < 3; d++) begin
            wr_ok = in_valid && m_rdy[d];
            cons  = pv_user && (d == 2 || !m_ph[d]);
            fill  = 1'b0;
            if (cons) begin
                if (mq[d].size() > 0) begin
                    m_cur[d] = mq[d].pop_front();
                end else begin
                    m_cur[d] = FILL;
                    fill     = 1'b1;
                end
            end
            lo = ((d == 0) == !m_ph[d]);
            if (!pv_user)    e_sym[d] = (d == 2) ? pv_sym : {4'h0, pv_sym[3:0]};
            else if (d == 2) e_sym[d] = m_cur[d];
            else             e_sym[d] = lo ? {4'h0, m_cur[d][3:0]} : {4'h0, m_cur[d][7:4]};
            e_und[d] = fill;
            if (pv_vld && !m_ovld)               m_fb[d] = cons ? 1 : 0;
            else if (cons && m_fb[d] < 65535)    m_fb[d]++;
            e_fb[d] = m_fb[d];
            if (d < 2) m_ph[d] = pv_user ? !m_ph[d] : 1'b0;
            if (wr_ok) mq[d].push_back(in_data);
            m_rdy[d] = (mq[d].size() < DEPTH);
            e_ss[d]  = !pv_vld && (mq[d].size() >= THRESH);
        end
        m_ovld  = pv_vld;
        e_vld   = pv_vld;
        pv_sym  = lane_in8;
        pv_user = lane_user;
        pv_vld  = lane_valid;
    endtask

    task automatic check_pipe();
        check("lane_out_lsn", 32'(lo0), 32'(e_sym[0]));
        check("lane_out_msn", 32'(lo1), 32'(e_sym[1]));
        check("lane_out_gmii", 32'(lo2), 32'(e_sym[2]));
        check("frame_bytes_lsn", 32'(fb0), 32'(e_fb[0]));
        check("frame_bytes_msn", 32'(fb1), 32'(e_fb[1]));
        check("frame_bytes_gmii", 32'(fb2), 32'(e_fb[2]));
        for (int d = 0; d < 3; d++) begin
            check($sformatf("out_valid%0d", d), 32'(lane_out_valid[d]), 32'(e_vld));
            check($sformatf("underrun%0d", d), 32'(underrun[d]), 32'(e_und[d]));
            check($sformatf("start_send%0d", d), 32'(start_send[d]), 32'(e_ss[d]));
        end
    endtask

    task automatic check_level();
        check("level_lsn", 32'(lvl0), 32'(mq[0].size()));
        check("level_msn", 32'(lvl1), 32'(mq[1].size()));
        check("level_gmii", 32'(lvl2), 32'(mq[2].size()));
        for (int d = 0; d < 3; d++) begin
            check($sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(m_rdy[d]));
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out"}, {lo0, lo1, lo2}, 32'h0);
        check({tag, "_flags"}, {in_ready, lane_out_valid, start_send, underrun}, 32'h0);
        check({tag, "_level"}, {lvl0, lvl1, lvl2}, 32'h0);
        check({tag, "_fb"}, {fb0, fb1}, 32'h0);
        check({tag, "_fb_gmii"}, 32'(fb2), 32'h0);
    endtask

    task automatic step(input bit iv, input logic [7:0] id, input bit lv, input bit lu, input logic [7:0] li);
        in_valid   = iv;
        in_data    = id;
        lane_valid = lv;
        lane_user  = lu;
        lane_in8   = li;
        @(posedge eth_clk);
        #1;
        check_pipe();
        model_step();
        check_level();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        reset_checks("rst_async");
        model_reset();
        in_valid = 1'b0; lane_valid = 1'b0; lane_user = 1'b0; lane_in8 = 8'h00; in_data = 8'h00;
        repeat (n) @(posedge eth_clk);
        #1;
        reset_checks("rst_hold");
        rst = 1'b0;
        #1;
        check("ready_after_release", 32'(in_ready), 32'h0);
    endtask

    // A frame: leading non-user slot, n user slots, trailing non-user slot.
    task automatic frame(input int n);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'hEE);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h55);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_random(input int n);
        int  left, gap, pos;
        bit  lv, lu;
        left = 0; gap = 2; pos = 0;
        for (int c = 0; c < n; c++) begin
            lv = 1'b0; lu = 1'b0;
            if (left == 0 && gap == 0) begin
                left = $urandom_range(3, 30);
                pos  = 0;
            end
            if (left > 0) begin
                lv = 1'b1;
                lu = (pos != 0) && (left != 1) && ($urandom_range(0, 9) != 0);
                pos++;
                left--;
                if (left == 0) gap = $urandom_range(1, 8);
            end else begin
                gap--;
            end
            step($urandom_range(0, 9) < 6, 8'($urandom), lv, lu, 8'($urandom));
        end
    endtask

    initial begin
        do_reset(3);

        // Idle pass-through of a framed non-user symbol.
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h05);
        idle(4);

        step(1'b1, 8'hA7, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        frame(4);
        idle(4);
        check("mii_frame_bytes", 32'(fb0), 32'd2);
        check("mii_level_drained", 32'(lvl0), 32'd0);
        check("gmii_frame_bytes", 32'(fb2), 32'd4);

        step(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
        frame(4);
        idle(4);
        check("underrun_frame_bytes", 32'(fb0), 32'd2);

        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
        frame(3);
        frame(2);
        idle(4);

        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
        idle(2);
        check("full_level", 32'(lvl0), 32'd16);
        check("full_ready", 32'(in_ready[0]), 32'd0);
        check("thresh_start", 32'(start_send[0]), 32'd1);
        frame(20);
        idle(4);

        run_random(2500);
        run_random(37);
        do_reset(2);
        run_random(1500);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
